ha_result_packer: RTL and testbench

- Downstream consumer of the bit-level half-adder stage in axis_mul.
- Accepts {carry, sum} result pairs over a valid/ready handshake and packs PAIRS_PER_WORD pairs into one word.
- Buffers completed words in a small FIFO and emits them as an AXI-Stream master, asserting tlast every WORDS_PER_PKT words.

---
 rtl/ha_pkg.sv | 18 +
 rtl/ha_result_packer_if.sv | 15 +
 rtl/ha_sync_fifo.sv | 62 ++++++
 rtl/ha_result_packer.sv | 166 ++++++++++++++++
 tb/tb_ha_result_packer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ha_pkg.sv
// Shared types and helpers for the half-adder result packer.
// Holds the assembler state encoding, the width of one {carry, sum} pair,
// and a helper that sizes counters able to hold the value max_val.
package ha_pkg;

    localparam int PAIR_W = 2;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } asm_state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ha_result_packer_if.sv
// AXI-Stream word channel leaving the result packer.
// master: the packer driving words; slave: the downstream consumer.
interface ha_result_packer_if #(
    parameter int DATA_W = 16
) ();

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/ha_sync_fifo.sv
// Small synchronous FIFO for completed words (data plus tlast per entry).
// DEPTH must be a power of two so the pointers wrap naturally.
// A pop is honoured only when not empty; a push into a full FIFO is
// honoured only when a pop happens in the same cycle (no fall-through).
module ha_sync_fifo
    import ha_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [WIDTH-1:0]                din,
    input  logic                            pop,
    output logic [WIDTH-1:0]                dout,
    output logic                            full,
    output logic                            empty,
    output logic [cnt_width(DEPTH)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; everything clears so a reset drops all queued words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ha_result_packer.sv
// Packs {carry, sum} pairs from the half-adder stage into words and streams
// them out over AXI-Stream, with tlast every WORDS_PER_PKT words.
// Pair k of a word lands in tdata[2k+1:2k]. A word that completes while the
// FIFO is full waits in a hold register, stalling the pair input.
// Optional feature macro: HA_PACKER_FLUSH_EN adds flush_in, which pushes a
// partial word (zero-padded, tlast=1) and restarts the packet count.
module ha_result_packer
    import ha_pkg::*;
#(
    parameter int PAIRS_PER_WORD = 8,
    parameter int WORDS_PER_PKT  = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sum_in,
    input  logic                                carry_in,
    input  logic                                valid_in,
    output logic                                ready_out,
`ifdef HA_PACKER_FLUSH_EN
    input  logic                                flush_in,
`endif
    ha_result_packer_if.master                  m_axis,
    output logic [cnt_width(FIFO_DEPTH)-1:0]    word_count
);

    localparam int DATA_W = PAIR_W * PAIRS_PER_WORD;
    localparam int PCW    = cnt_width(PAIRS_PER_WORD);
    localparam int KCW    = cnt_width(WORDS_PER_PKT);

`ifndef HA_PACKER_FLUSH_EN
    logic flush_in;
    assign flush_in = 1'b0;
`endif

    asm_state_t         state_q, state_d;
    logic [PCW-1:0]     pair_cnt_q, pair_cnt_d;
    logic [KCW-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0]  partial_q, partial_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               hold_flush_q, hold_flush_d;
    logic               rst_hold_q;

    logic               accept;
    logic               pop;
    logic               can_push;
    logic               flush_go;
    logic               last_of_pkt;
    logic               word_last;
    logic [DATA_W-1:0]  word_next;
    logic               push;
    logic [DATA_W-1:0]  push_data;
    logic               push_last;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W:0]    fifo_dout;

    assign ready_out     = !rst_hold_q && (state_q != HOLD);
    assign accept        = valid_in && ready_out;
    assign m_axis.tvalid = !fifo_empty;
    assign pop           = m_axis.tvalid && m_axis.tready;
    assign can_push      = !fifo_full || pop;
    assign m_axis.tdata  = fifo_dout[DATA_W-1:0];
    assign m_axis.tlast  = fifo_dout[DATA_W];

    // Keeps the input stalled for one clock after reset falls so deassertion is seen synchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_hold_q <= 1'b1;
        end else begin
            rst_hold_q <= 1'b0;
        end
    end

    // Assembler state, counters, partial word and hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            pair_cnt_q   <= '0;
            pkt_cnt_q    <= '0;
            partial_q    <= '0;
            hold_q       <= '0;
            hold_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pair_cnt_q   <= pair_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            partial_q    <= partial_d;
            hold_q       <= hold_d;
            hold_flush_q <= hold_flush_d;
        end
    end

    // Next-state logic: insert accepted pairs, complete or flush words, push or park them.
    always_comb begin
        state_d      = state_q;
        pair_cnt_d   = pair_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        partial_d    = partial_q;
        hold_d       = hold_q;
        hold_flush_d = hold_flush_q;
        push         = 1'b0;
        push_data    = '0;
        push_last    = 1'b0;
        word_last    = 1'b0;
        word_next    = partial_q;
        last_of_pkt  = (pkt_cnt_q == KCW'(WORDS_PER_PKT - 1));
        flush_go     = flush_in && (state_q != HOLD) && (pair_cnt_q != '0);

        if (accept) begin
            word_next[PAIR_W*pair_cnt_q +: PAIR_W] = {carry_in, sum_in};
        end

        case (state_q)
            HOLD: begin
                if (!fifo_full) begin
                    push         = 1'b1;
                    push_data    = hold_q;
                    push_last    = hold_flush_q || last_of_pkt;
                    pkt_cnt_d    = push_last ? '0 : pkt_cnt_q + 1'b1;
                    hold_flush_d = 1'b0;
                    state_d      = EMPTY;
                end
            end
            default: begin
                if (accept) begin
                    pair_cnt_d = pair_cnt_q + 1'b1;
                    partial_d  = word_next;
                    state_d    = COLLECT;
                end
                if ((accept && pair_cnt_q == PCW'(PAIRS_PER_WORD - 1)) || flush_go) begin
                    word_last  = flush_go || last_of_pkt;
                    pair_cnt_d = '0;
                    partial_d  = '0;
                    if (can_push) begin
                        push      = 1'b1;
                        push_data = word_next;
                        push_last = word_last;
                        pkt_cnt_d = word_last ? '0 : pkt_cnt_q + 1'b1;
                        state_d   = EMPTY;
                    end else begin
                        hold_d       = word_next;
                        hold_flush_d = flush_go;
                        state_d      = HOLD;
                    end
                end
            end
        endcase
    end

    ha_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({push_last, push_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (word_count)
    );

endmodule

// File: tb/tb_ha_result_packer.sv
// Bench for ha_result_packer with PAIRS_PER_WORD=4, WORDS_PER_PKT=2, FIFO_DEPTH=4.
// Expected words come from a pair-list model: every PAIRS_PER_WORD accepted
// pairs form one word, tlast marks every WORDS_PER_PKT-th word, and a flush
// closes a non-empty partial word with tlast=1.
module tb_ha_result_packer;

    localparam int P  = 4;
    localparam int K  = 2;
    localparam int FD = 4;
    localparam int DW = 2 * P;

`ifdef HA_PACKER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sum_in;
    logic       carry_in;
    logic       valid_in;
    logic       ready_out;
    logic       flush_in;
    logic [2:0] word_count;

    int checks = 0;
    int errors = 0;

    word_t         exp_q[$];
    logic [DW:0]   seen_q[$];
    logic [DW-1:0] cur_word;
    int            cur_pairs;
    int            pkt_pos;
    bit            prev_pop;

    ha_result_packer_if #(.DATA_W(DW)) m_axis ();

    ha_result_packer #(
        .PAIRS_PER_WORD (P),
        .WORDS_PER_PKT  (K),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sum_in     (sum_in),
        .carry_in   (carry_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
`ifdef HA_PACKER_FLUSH_EN
        .flush_in   (flush_in),
`endif
        .m_axis     (m_axis),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelClear();
        exp_q.delete();
        cur_word  = '0;
        cur_pairs = 0;
        pkt_pos   = 0;
    endtask

    // One clock of stimulus; checks the output side and updates the model at the falling edge.
    task automatic applyStimulus(input logic v, input logic c, input logic s, input logic tr, input logic fl);
        logic  acc;
        logic  pop;
        bit    flush_eff;
        int    size;
        word_t w;
        valid_in      = v;
        carry_in      = c;
        sum_in        = s;
        m_axis.tready = tr;
        flush_in      = fl;
        @(negedge clk);
        size = exp_q.size();
        checkOutput("tvalid", 32'(m_axis.tvalid), 32'(size != 0));
        if (!prev_pop) begin
            checkOutput("word_count", 32'(word_count), 32'((size < FD) ? size : FD));
            checkOutput("ready_out", 32'(ready_out), 32'(size <= FD));
        end
        acc = v && ready_out;
        pop = m_axis.tvalid && tr;
        if (pop) begin
            seen_q.push_back({m_axis.tlast, m_axis.tdata});
            if (size == 0) begin
                checkOutput("unexpected_word", 32'(m_axis.tdata), 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                checkOutput("tdata", 32'(m_axis.tdata), 32'(w.data));
                checkOutput("tlast", 32'(m_axis.tlast), 32'(w.last));
            end
        end
        flush_eff = FLUSH_EN && fl && (cur_pairs > 0);
        if (acc) begin
            cur_word  = cur_word | (DW'({c, s}) << (2 * cur_pairs));
            cur_pairs = cur_pairs + 1;
        end
        if (cur_pairs == P || flush_eff) begin
            w.data = cur_word;
            w.last = flush_eff || (pkt_pos == K - 1);
            exp_q.push_back(w);
            pkt_pos   = w.last ? 0 : pkt_pos + 1;
            cur_word  = '0;
            cur_pairs = 0;
        end
        prev_pop = pop;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst           = 1'b1;
        valid_in      = 1'b0;
        m_axis.tready = 1'b0;
        flush_in      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        modelClear();
        seen_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        prev_pop = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc_cnt;
        logic r;
        rst           = 1'b1;
        valid_in      = 1'b0;
        carry_in      = 1'b0;
        sum_in        = 1'b0;
        flush_in      = 1'b0;
        m_axis.tready = 1'b0;
        prev_pop      = 1'b0;
        modelClear();

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(ready_out), 32'd0);
        checkOutput("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
        checkOutput("rst_tlast", 32'(m_axis.tlast), 32'd0);
        checkOutput("rst_tdata", 32'(m_axis.tdata), 32'd0);
        checkOutput("rst_count", 32'(word_count), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_ready", 32'(ready_out), 32'd1);
        checkOutput("post_rst_tvalid", 32'(m_axis.tvalid), 32'd0);

        // Four directed pairs form 0x49, visible one cycle after the fourth accept.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("w49_tvalid", 32'(m_axis.tvalid), 32'd1);
        checkOutput("w49_tdata", 32'(m_axis.tdata), 32'h49);
        checkOutput("w49_tlast", 32'(m_axis.tlast), 32'd0);
        drain("w49_drain");

        // Twelve (1,0) pairs: tlast pattern 0,1,0 across three 0xAA words.
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        drain("aa_drain");
        checkOutput("aa_count", 32'(seen_q.size()), 32'd3);
        if (seen_q.size() == 3) begin
            checkOutput("aa_word0", 32'(seen_q[0]), 32'h0AA);
            checkOutput("aa_word1", 32'(seen_q[1]), 32'h1AA);
            checkOutput("aa_word2", 32'(seen_q[2]), 32'h0AA);
        end

        // Backpressure: 20 pairs with tready low fill the FIFO and park one word.
        doReset();
        acc_cnt = 0;
        for (int i = 0; i < 40 && acc_cnt < 20; i++) begin
            r = ready_out;
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (r) acc_cnt++;
        end
        checkOutput("fill_accepts", 32'(acc_cnt), 32'd20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("full_ready", 32'(ready_out), 32'd0);
        checkOutput("full_count", 32'(word_count), 32'd4);
        drain("full_drain");
        checkOutput("full_ready_back", 32'(ready_out), 32'd1);

        // Asynchronous reset with a queued word and a partial word.
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        rst = 1'b1;
        #2;
        checkOutput("arst_tvalid", 32'(m_axis.tvalid), 32'd0);
        checkOutput("arst_count", 32'(word_count), 32'd0);
        checkOutput("arst_ready", 32'(ready_out), 32'd0);
        @(posedge clk);
        #1;
        modelClear();
        rst = 1'b0;
        @(posedge clk);
        #1;
        prev_pop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("fresh_tdata", 32'(m_axis.tdata), 32'h55);
        checkOutput("fresh_tlast", 32'(m_axis.tlast), 32'd0);
        drain("fresh_drain");

        if (FLUSH_EN) begin
            // Three pairs then a flush: zero-padded 0x15 with tlast.
            doReset();
            for (int i = 0; i < 3; i++) begin
                applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            checkOutput("flush_tdata", 32'(m_axis.tdata), 32'h15);
            checkOutput("flush_tlast", 32'(m_axis.tlast), 32'd1);
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            end
            drain("flush_drain");
        end

        // Randomised traffic with random backpressure (and occasional flushes when enabled).
        doReset();
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 9) < 7),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) < 6),
                          1'(FLUSH_EN && ($urandom_range(0, 19) == 0)));
        end
        drain("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
